softmax_sequencer: RTL

Sequences the SoftMax classifier stage at the tail of the CNN pipeline. It accepts the DATA_NUM fully-connected logits over a valid/ready stream and holds them in a local logit buffer that serves the SoftMax read port. It launches SoftMax, monitors its output writes to track the arg-max class and its probability, then presents the result downstream with a valid/ready handshake.

---
 rtl/softmax_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/softmax_sequencer.sv
// softmax_sequencer
//
// Frame sequencer for the SoftMax classifier stage. Collects DATA_NUM logits from
// an upstream valid/ready stream into a local buffer, launches SoftMax, tracks the
// arg-max of the probabilities SoftMax writes back, and offers the winning class
// and its probability downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   s_valid, s_ready, s_data     logit input stream, class order 0..DATA_NUM-1
//   sm_start                     one-cycle SoftMax launch pulse
//   sm_done                      SoftMax idle level
//   sm_adrIn, sm_dataIn          SoftMax logit read port into the local buffer
//   sm_adrOut, sm_dataOut, sm_wr SoftMax probability write-back observed here
//   m_valid, m_ready             result handshake
//   m_class, m_prob              arg-max class and its probability
//   busy                         high whenever not accepting logits

module softmax_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_NUM   = 10,
    parameter int unsigned ADR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  sm_start,
    input  logic                  sm_done,
    input  logic [ADR_WIDTH-1:0]  sm_adrIn,
    output logic [DATA_WIDTH-1:0] sm_dataIn,
    input  logic [ADR_WIDTH-1:0]  sm_adrOut,
    input  logic [DATA_WIDTH-1:0] sm_dataOut,
    input  logic                  sm_wr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADR_WIDTH-1:0]  m_class,
    output logic [DATA_WIDTH-1:0] m_prob,
    output logic                  busy
);

    localparam logic [ADR_WIDTH-1:0] LastIdx = ADR_WIDTH'(DATA_NUM - 1);

    typedef enum logic [1:0] {
        StLoad,
        StLaunch,
        StRun,
        StResult
    } state_e;

    state_e                state_q, state_d;
    logic [ADR_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [ADR_WIDTH-1:0]  rcnt_q, rcnt_d;
    logic [ADR_WIDTH-1:0]  best_class_q, best_class_d;
    logic [DATA_WIDTH-1:0] best_prob_q, best_prob_d;
    logic [DATA_WIDTH-1:0] logit_buf_q [DATA_NUM];
    logic                  buf_we;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        best_class_d = best_class_q;
        best_prob_d  = best_prob_q;
        buf_we       = 1'b0;
        s_ready      = 1'b0;
        sm_start     = 1'b0;
        m_valid      = 1'b0;
        busy         = 1'b1;

        unique case (state_q)
            StLoad: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    buf_we = 1'b1;
                    if (wcnt_q == LastIdx) begin
                        wcnt_d  = '0;
                        state_d = StLaunch;
                    end else begin
                        wcnt_d = wcnt_q + ADR_WIDTH'(1);
                    end
                end
            end
            StLaunch: begin
                rcnt_d   = '0;
                // Start only when SoftMax reports idle; it leaves idle on the next edge.
                sm_start = sm_done;
                if (sm_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (sm_wr) begin
                    // First write always loads so a stale best from the last frame never wins;
                    // strict compare keeps the lower index on ties.
                    if ((rcnt_q == '0) || (sm_dataOut > best_prob_q)) begin
                        best_prob_d  = sm_dataOut;
                        best_class_d = sm_adrOut;
                    end
                    if (rcnt_q == LastIdx) begin
                        rcnt_d  = '0;
                        state_d = StResult;
                    end else begin
                        rcnt_d = rcnt_q + ADR_WIDTH'(1);
                    end
                end
            end
            StResult: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            best_class_q <= '0;
            best_prob_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            best_class_q <= best_class_d;
            best_prob_q  <= best_prob_d;
        end
    end

    // Logit buffer has no reset; it is fully rewritten every frame before use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            logit_buf_q[wcnt_q] <= s_data;
        end
    end

    always_comb begin
        sm_dataIn = '0;
        if (sm_adrIn <= LastIdx) begin
            sm_dataIn = logit_buf_q[sm_adrIn];
        end
    end

    assign m_class = best_class_q;
    assign m_prob  = best_prob_q;

endmodule
